mpu_dispatch: RTL
=================

Name: mpu_dispatch

Overview:
- In-order command scheduler for the matrix processing unit.
- Accepts LOAD, STORE and MULT commands through a valid/ready FIFO.
- Sequences the load unit, store unit and multiply cluster one operation at a time.
- Keeps a per-register validity/dimension table so that illegal commands are rejected before they reach any datapath unit.

Parameters:
- NUM_REGS, 4: matrix registers tracked. Register index width RW = MATRIX_REG_SIZE.
- FIFO_DEPTH, 4: command FIFO entries. Must be a power of two, at least 2.
- MBITS / NBITS: taken from global_defs. Dimension fields are [MBITS:0] and [NBITS:0].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active low
- cmd_valid_in  in  1  command valid
- cmd_ready_out  out  1  FIFO not full
- cmd_op_in  in  2  0=NOP, 1=LOAD, 2=STORE, 3=MULT
- cmd_dst_in  in  RW  LOAD/MULT destination register
- cmd_src1_in  in  RW  STORE source; MULT left operand
- cmd_src2_in  in  RW  MULT right operand
- cmd_m_in  in  MBITS+1  LOAD rows
- cmd_n_in  in  NBITS+1  LOAD columns
- load_en_out  out  1  one-cycle load start pulse
- load_addr_out  out  RW  load destination register
- load_m_out  out  MBITS+1  load rows
- load_n_out  out  NBITS+1  load columns
- load_done_in  in  1  load complete pulse
- store_en_out  out  1  held high for the store duration
- store_addr_out  out  RW  register being stored
- mult_en_out  out  1  one-cycle multiply start pulse
- mult_dst_out  out  RW  multiply destination register
- mult_src1_out  out  RW  multiply left operand
- mult_src2_out  out  RW  multiply right operand
- mult_done_in  in  1  multiply complete pulse
- busy_out  out  1  state != IDLE or FIFO not empty
- error_out  out  1  sticky error flag; cleared only by reset
- err_code_out  out  2  first error cause: 1=unloaded source, 2=dim mismatch, 3=zero-size load

Behaviour:
- Reset (rst==0 at a clk edge):
  - FIFO emptied, validity table cleared, state=IDLE.
  - All enables 0, all address/dimension outputs 0, error_out=0, err_code_out=0, cmd_ready_out=1.
  - Reset mid-operation abandons the operation immediately. Any done pulse arriving afterwards is ignored.
- FIFO:
  - Push when cmd_valid_in && cmd_ready_out. cmd_ready_out = !full.
  - Push and pop in the same cycle is legal, including when full: pop frees a slot next cycle only, so ready stays low that cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- States:
  - IDLE: if FIFO not empty, pop head into a command register and go to DECODE.
  - DECODE:
    - NOP -> IDLE.
    - LOAD: m==0 or n==0 -> error 3, go to IDLE. Otherwise pulse load_en_out for one cycle with address/dims, then go to LOAD_WAIT.
    - STORE: valid[src1]==0 -> error 1, go to IDLE. Otherwise load cnt = M[src1]*N[src1] (width MBITS+NBITS+2), assert store_en_out, go to STORE_RUN.
    - MULT: either source invalid -> error 1. N[src1] != M[src2] -> error 2. Either error goes to IDLE. Otherwise pulse mult_en_out, go to MULT_WAIT.
  - LOAD_WAIT: on load_done_in, set valid[dst]=1, M[dst]=m, N[dst]=n, go to IDLE.
  - STORE_RUN:
    - store_en_out and store_addr_out held stable; cnt decrements each cycle.
    - When cnt reaches 1, store_en_out drops the following cycle. Total high time is exactly M*N cycles.
    - Then go to IDLE.
  - MULT_WAIT: on mult_done_in, set valid[dst]=1, M[dst]=M[src1], N[dst]=N[src2], go to IDLE.
    - dst may equal a source; the table is updated only at done.
- Latency: a command accepted at edge k into an empty FIFO with state IDLE gives its enable high in the cycle after edge k+2.
- Done pulses arriving outside the matching WAIT state are ignored.
- Error handling:
  - An erroring command is dropped; dispatch continues with the next command.
  - err_code_out latches only the first error.
- Address/dimension outputs hold their last issued values between operations.

Test Plan:
1. Reset, then LOAD dst=2 m=3 n=4 -> load_en_out single pulse, load_addr_out=2, load_m_out=3, load_n_out=4; after load_done_in, busy_out falls within 1 cycle.
2. After test 1, STORE src1=2 -> store_en_out high exactly 12 consecutive cycles with store_addr_out=2, then low; busy_out=0 afterwards.
3. LOAD r0 3x4, LOAD r1 4x2, MULT dst=3 src1=0 src2=1, STORE r3 -> one mult_en_out pulse; then store_en_out high for 6 cycles.
4. MULT with r0 3x4 and r1 3x2 -> no mult_en_out, error_out=1, err_code_out=2; a following STORE r0 still runs 12 cycles.
5. Push 6 back-to-back commands while a LOAD waits with no done -> cmd_ready_out low after 4 accepted (FIFO_DEPTH=4); commands drain in order once done pulses arrive.
6. Assert rst=0 during STORE_RUN of a 3x4 store -> store_en_out=0 the next cycle, FIFO empty; a subsequent STORE r2 gives error 1 because the table was cleared.

Source files
------------

// File: rtl/mpu_dispatch_if.sv
// Command bus into the MPU dispatcher: valid/ready handshake plus the command fields.
interface mpu_dispatch_if #(
  parameter int unsigned RW = 2,
  parameter int unsigned MW = 4,
  parameter int unsigned NW = 4
);
  logic          cmd_valid_in;
  logic          cmd_ready_out;
  logic [1:0]    cmd_op_in;
  logic [RW-1:0] cmd_dst_in;
  logic [RW-1:0] cmd_src1_in;
  logic [RW-1:0] cmd_src2_in;
  logic [MW-1:0] cmd_m_in;
  logic [NW-1:0] cmd_n_in;

  modport master (
    output cmd_valid_in, cmd_op_in, cmd_dst_in, cmd_src1_in, cmd_src2_in, cmd_m_in, cmd_n_in,
    input  cmd_ready_out
  );

  modport slave (
    input  cmd_valid_in, cmd_op_in, cmd_dst_in, cmd_src1_in, cmd_src2_in, cmd_m_in, cmd_n_in,
    output cmd_ready_out
  );
endinterface

// File: rtl/mpu_dispatch.sv
// In-order LOAD/STORE/MULT scheduler for the matrix processing unit, with a command FIFO
// and a per-register validity/dimension table that screens commands before issue.
module mpu_dispatch #(
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MBITS      = 3,
  parameter int unsigned NBITS      = 3,
  localparam int unsigned RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int unsigned MW = MBITS + 1,
  localparam int unsigned NW = NBITS + 1
) (
  input  logic          clk,
  input  logic          rst,
  mpu_dispatch_if.slave cmd,
  output logic          load_en_out,
  output logic [RW-1:0] load_addr_out,
  output logic [MW-1:0] load_m_out,
  output logic [NW-1:0] load_n_out,
  input  logic          load_done_in,
  output logic          store_en_out,
  output logic [RW-1:0] store_addr_out,
  output logic          mult_en_out,
  output logic [RW-1:0] mult_dst_out,
  output logic [RW-1:0] mult_src1_out,
  output logic [RW-1:0] mult_src2_out,
  input  logic          mult_done_in,
  output logic          busy_out,
  output logic          error_out,
  output logic [1:0]    err_code_out
);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = MW + NW;
  localparam logic [1:0] OP_LOAD = 2'd1, OP_STORE = 2'd2, OP_MULT = 2'd3;

  typedef struct packed {
    logic [1:0]    op;
    logic [RW-1:0] dst;
    logic [RW-1:0] src1;
    logic [RW-1:0] src2;
    logic [MW-1:0] m;
    logic [NW-1:0] n;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_LOAD_WAIT, S_STORE_RUN, S_MULT_WAIT} state_t;

  cmd_t              mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]   count_q, count_d;
  logic              ready_q, push, pop;
  cmd_t              cmd_in, cmd_q, cmd_d;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NUM_REGS-1:0] valid_q;
  logic [MW-1:0]     dim_m_q [NUM_REGS];
  logic [NW-1:0]     dim_n_q [NUM_REGS];

  logic              load_en_d, store_en_d, mult_en_d;
  logic [RW-1:0]     load_addr_d, store_addr_d, mult_dst_d, mult_src1_d, mult_src2_d;
  logic [MW-1:0]     load_m_d;
  logic [NW-1:0]     load_n_d;
  logic              err_set, tbl_we;
  logic [1:0]        err_val;
  logic [MW-1:0]     tbl_m;
  logic [NW-1:0]     tbl_n;

  assign cmd_in = '{op: cmd.cmd_op_in, dst: cmd.cmd_dst_in, src1: cmd.cmd_src1_in,
                    src2: cmd.cmd_src2_in, m: cmd.cmd_m_in, n: cmd.cmd_n_in};
  assign push = cmd.cmd_valid_in && ready_q;
  assign cmd.cmd_ready_out = ready_q;

  // FIFO occupancy; a pop only frees a slot from the next cycle on
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNTW'(1);
    else if (pop && !push) count_d = count_q - CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= cmd_in;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cnt_d        = cnt_q;
    pop          = 1'b0;
    load_en_d    = 1'b0;
    store_en_d   = 1'b0;
    mult_en_d    = 1'b0;
    load_addr_d  = load_addr_out;
    load_m_d     = load_m_out;
    load_n_d     = load_n_out;
    store_addr_d = store_addr_out;
    mult_dst_d   = mult_dst_out;
    mult_src1_d  = mult_src1_out;
    mult_src2_d  = mult_src2_out;
    err_set      = 1'b0;
    err_val      = 2'd0;
    tbl_we       = 1'b0;
    tbl_m        = cmd_q.m;
    tbl_n        = cmd_q.n;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          cmd_d   = mem[rd_ptr_q];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_IDLE;
        case (cmd_q.op)
          OP_LOAD: begin
            if (cmd_q.m == '0 || cmd_q.n == '0) begin
              err_set = 1'b1;
              err_val = 2'd3;
            end else begin
              load_en_d   = 1'b1;
              load_addr_d = cmd_q.dst;
              load_m_d    = cmd_q.m;
              load_n_d    = cmd_q.n;
              state_d     = S_LOAD_WAIT;
            end
          end
          OP_STORE: begin
            if (!valid_q[cmd_q.src1]) begin
              err_set = 1'b1;
              err_val = 2'd1;
            end else begin
              cnt_d        = CW'(dim_m_q[cmd_q.src1]) * CW'(dim_n_q[cmd_q.src1]);
              store_en_d   = 1'b1;
              store_addr_d = cmd_q.src1;
              state_d      = S_STORE_RUN;
            end
          end
          OP_MULT: begin
            if (!valid_q[cmd_q.src1] || !valid_q[cmd_q.src2]) begin
              err_set = 1'b1;
              err_val = 2'd1;
            end else if (CW'(dim_n_q[cmd_q.src1]) != CW'(dim_m_q[cmd_q.src2])) begin
              err_set = 1'b1;
              err_val = 2'd2;
            end else begin
              mult_en_d   = 1'b1;
              mult_dst_d  = cmd_q.dst;
              mult_src1_d = cmd_q.src1;
              mult_src2_d = cmd_q.src2;
              state_d     = S_MULT_WAIT;
            end
          end
          default: ;
        endcase
      end
      S_LOAD_WAIT: begin
        if (load_done_in) begin
          tbl_we  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_STORE_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = S_IDLE;
        else                 store_en_d = 1'b1;
      end
      S_MULT_WAIT: begin
        if (mult_done_in) begin
          tbl_we  = 1'b1;
          tbl_m   = dim_m_q[cmd_q.src1];
          tbl_n   = dim_n_q[cmd_q.src2];
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register table: dims are only meaningful where the valid bit is set
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      dim_m_q[cmd_q.dst] <= tbl_m;
      dim_n_q[cmd_q.dst] <= tbl_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      cmd_q          <= '0;
      cnt_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      ready_q        <= 1'b1;
      valid_q        <= '0;
      load_en_out    <= 1'b0;
      load_addr_out  <= '0;
      load_m_out     <= '0;
      load_n_out     <= '0;
      store_en_out   <= 1'b0;
      store_addr_out <= '0;
      mult_en_out    <= 1'b0;
      mult_dst_out   <= '0;
      mult_src1_out  <= '0;
      mult_src2_out  <= '0;
      busy_out       <= 1'b0;
      error_out      <= 1'b0;
      err_code_out   <= 2'd0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      cnt_q          <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q        <= count_d;
      ready_q        <= (count_d != CNTW'(FIFO_DEPTH));
      if (tbl_we) valid_q[cmd_q.dst] <= 1'b1;
      load_en_out    <= load_en_d;
      load_addr_out  <= load_addr_d;
      load_m_out     <= load_m_d;
      load_n_out     <= load_n_d;
      store_en_out   <= store_en_d;
      store_addr_out <= store_addr_d;
      mult_en_out    <= mult_en_d;
      mult_dst_out   <= mult_dst_d;
      mult_src1_out  <= mult_src1_d;
      mult_src2_out  <= mult_src2_d;
      busy_out       <= (state_d != S_IDLE) || (count_d != '0);
      if (err_set) begin
        error_out <= 1'b1;
        if (!error_out) err_code_out <= err_val;
      end
    end
  end
endmodule
